ddr3_rdback_adapter: RTL and testbench
======================================

Name: ddr3_rdback_adapter

Overview:
- Return-path counterpart of the DDR3 command adapter: accepts read data bursts from the PHY MC read interface and matches each burst, in order, to the READ command that produced it.
- Discards bursts belonging to maintenance reads.
- Buffers user read data into a small output FIFO with a valid/ready handshake toward the readback path.
- Tracks outstanding reads and flags protocol errors as sticky status bits.

Parameters:
- DATA_W, 512, width of one PHY read burst (8 beats x 64 bits).
- TAG_DEPTH, 16, maximum number of outstanding READs tracked; power of two.
- OUT_DEPTH, 4, output FIFO depth in bursts; power of two.
- TIMEOUT, 255, idle cycles allowed with reads outstanding before err_timeout is set; 8-bit counter.

Ports:
- clk  in  1  fabric/PHY MC clock.
- rst  in  1  synchronous, active-high reset.
- init_calib_complete  in  1  PHY calibration done; issue and return are ignored while low.
- rd_issue  in  1  pulse, one cycle per READ command enqueued to the PHY.
- rd_issue_maint  in  1  qualifies rd_issue: the READ is a maintenance read.
- phy_rddata_valid  in  1  PHY read burst valid; cannot be backpressured.
- phy_rd_data  in  DATA_W  PHY read burst.
- rdback_data  out  DATA_W  head of output FIFO.
- rdback_valid  out  1  output FIFO non-empty.
- rdback_ready  in  1  consumer accepts head when valid & ready.
- outstanding  out  $clog2(TAG_DEPTH+1)  READs issued but not yet returned.
- idle  out  1  outstanding==0 and output FIFO empty.
- err_unexpected  out  1  sticky: burst returned with no outstanding READ.
- err_overflow  out  1  sticky: user burst dropped because the output FIFO was full.
- err_tag_full  out  1  sticky: READ issued with TAG_DEPTH already outstanding.
- err_timeout  out  1  sticky: reads outstanding and no burst for TIMEOUT+1 cycles.

Behaviour:
- Reset values:
  - rdback_valid=0, rdback_data=0, outstanding=0, idle=1.
  - All err_* = 0; tag FIFO and output FIFO empty; timeout counter=0.
  - Reset mid-operation discards all in-flight tags and buffered data; no error is flagged for them.
- Qualification: iss = rd_issue & init_calib_complete; ret = phy_rddata_valid & init_calib_complete.
- Tag FIFO (TAG_DEPTH x 1 bit, stores rd_issue_maint):
  - Push on iss; pop on ret.
  - Pop is evaluated before push in the same cycle. With the FIFO empty and iss & ret together, the pop is unexpected and the push then succeeds.
  - Full with iss & ret together: push and pop both succeed.
  - Full with iss and no ret: tag dropped, err_tag_full set, outstanding unchanged.
- outstanding: +1 on accepted push, -1 on successful pop, unchanged when both occur. Never wraps.
- Return handling on ret:
  - Tag FIFO empty: data dropped, err_unexpected set.
  - Popped tag = 1 (maintenance): data dropped silently.
  - Popped tag = 0 (user): data written to the output FIFO.
  - Output FIFO full and no read in the same cycle: data dropped, err_overflow set, and the tag is still consumed.
  - Output FIFO full with a read in the same cycle: the write is allowed.
- Output FIFO:
  - First-word-fall-through; write-to-rdback_valid latency is 1 cycle (registered).
  - Read on rdback_valid & rdback_ready.
  - Simultaneous read and write is legal at any occupancy.
  - Pointers wrap modulo OUT_DEPTH.
  - rdback_data holds its value while valid & !ready.
- Timeout:
  - Counter clears on ret or when outstanding==0.
  - Otherwise it increments and saturates at TIMEOUT.
  - err_timeout is set on the cycle the counter is at TIMEOUT and it still has no ret.
- Sticky errors clear only on rst.
- idle is combinational from registered state.

Test Plan:
- Single user read: 1 rd_issue (maint=0), return 0xA5..A5 three cycles later with rdback_ready=1 -> rdback_valid high for 1 cycle starting 1 cycle after ret, data 0xA5..A5, outstanding goes 0->1->0, idle=1 at end.
- Maintenance interleave: issue user, maint, user; return bursts D0, D1, D2 -> only D0 and D2 appear on rdback_data, in order; all err_* = 0.
- Backpressure overflow: rdback_ready=0, issue and return 5 user bursts (OUT_DEPTH=4) -> first 4 are retained, 5th is dropped, err_overflow=1. Then ready=1 -> exactly 4 bursts are drained in order.
- Unexpected and tag full:
  - ret with nothing outstanding -> err_unexpected=1, no output.
  - 17 issues with no return -> outstanding=16, err_tag_full=1.
  - 17 issues with iss & ret in the same cycle at full -> outstanding stays 16, no error.
- Timeout: 1 issue and no return -> err_timeout asserts on the 256th cycle after issue. Repeat with the return on cycle 200 -> err_timeout stays 0.
- Reset mid-flight: 3 issues, 1 burst buffered, assert rst for 1 cycle -> outstanding=0, rdback_valid=0, idle=1. A subsequent return sets err_unexpected.

Source files
------------

// File: rtl/ddr3_rdback_adapter.sv
// ddr3_rdback_adapter: matches PHY read bursts in order to issued READs, drops maintenance data, buffers user data
module ddr3_rdback_adapter #(
  parameter int DATA_W    = 512,
  parameter int TAG_DEPTH = 16,
  parameter int OUT_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             init_calib_complete,
  input  logic                             rd_issue,
  input  logic                             rd_issue_maint,
  input  logic                             phy_rddata_valid,
  input  logic [DATA_W-1:0]                phy_rd_data,
  output logic [DATA_W-1:0]                rdback_data,
  output logic                             rdback_valid,
  input  logic                             rdback_ready,
  output logic [$clog2(TAG_DEPTH+1)-1:0]   outstanding,
  output logic                             idle,
  output logic                             err_unexpected,
  output logic                             err_overflow,
  output logic                             err_tag_full,
  output logic                             err_timeout
);
  localparam int TW  = $clog2(TAG_DEPTH);
  localparam int OW  = $clog2(OUT_DEPTH);
  localparam int CW  = $clog2(TAG_DEPTH+1);
  localparam int OCW = $clog2(OUT_DEPTH+1);
  localparam logic [CW-1:0]  TAG_MAX = CW'(TAG_DEPTH);
  localparam logic [OCW-1:0] OUT_MAX = OCW'(OUT_DEPTH);
  localparam logic [7:0]     TMO     = 8'(TIMEOUT);
  logic              tag_mem [TAG_DEPTH];
  logic [DATA_W-1:0] out_mem [OUT_DEPTH];
  logic [TW-1:0]     tag_wp, tag_rp;
  logic [OW-1:0]     out_wp, out_rp;
  logic [OCW-1:0]    out_cnt;
  logic [7:0]        tmo_cnt;
  logic              iss, ret, pop, push, user, rd, wr;
  // pop is resolved first so a full tag FIFO can still accept a push alongside a return
  always_comb begin
    iss  = rd_issue & init_calib_complete;
    ret  = phy_rddata_valid & init_calib_complete;
    pop  = ret & (outstanding != '0);
    push = iss & ((outstanding != TAG_MAX) | pop);
    user = pop & !tag_mem[tag_rp];
    rd   = rdback_valid & rdback_ready;
    wr   = user & ((out_cnt != OUT_MAX) | rd);
  end
  assign rdback_valid = out_cnt != '0;
  assign rdback_data  = rdback_valid ? out_mem[out_rp] : '0;
  assign idle         = (outstanding == '0) && (out_cnt == '0);
  always_ff @(posedge clk) begin
    if (push) tag_mem[tag_wp] <= rd_issue_maint;
    if (wr) out_mem[out_wp] <= phy_rd_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wp         <= '0;
      tag_rp         <= '0;
      outstanding    <= '0;
      out_wp         <= '0;
      out_rp         <= '0;
      out_cnt        <= '0;
      tmo_cnt        <= '0;
      err_unexpected <= 1'b0;
      err_overflow   <= 1'b0;
      err_tag_full   <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      tag_wp         <= tag_wp + TW'(push);
      tag_rp         <= tag_rp + TW'(pop);
      outstanding    <= outstanding + CW'(push) - CW'(pop);
      out_wp         <= out_wp + OW'(wr);
      out_rp         <= out_rp + OW'(rd);
      out_cnt        <= out_cnt + OCW'(wr) - OCW'(rd);
      tmo_cnt        <= (ret || outstanding == '0) ? '0 : (tmo_cnt == TMO ? tmo_cnt : tmo_cnt + 8'd1);
      err_unexpected <= err_unexpected | (ret & (outstanding == '0));
      err_overflow   <= err_overflow | (user & (out_cnt == OUT_MAX) & !rd);
      err_tag_full   <= err_tag_full | (iss & (outstanding == TAG_MAX) & !pop);
      err_timeout    <= err_timeout | (!ret & (outstanding != '0) & (tmo_cnt == TMO));
    end
  end
endmodule

// File: tb/tb_ddr3_rdback_adapter.sv
// tb_ddr3_rdback_adapter: directed and random stimulus against a queue-based model of the readback adapter
module tb_ddr3_rdback_adapter;
  localparam int DW = 512, TD = 16, OD = 4;
  logic clk = 0, rst = 1, cal = 0;
  logic rd_issue = 0, rd_issue_maint = 0, phy_rddata_valid = 0, rdback_ready = 0;
  logic [DW-1:0] phy_rd_data = '0, rdback_data;
  logic rdback_valid, idle, err_unexpected, err_overflow, err_tag_full, err_timeout;
  logic [4:0] outstanding;
  int errors = 0, checks = 0;
  bit tq[$];
  logic [DW-1:0] oq[$];
  bit m_unexp, m_ovf, m_full, m_tmo;
  int quiet;
  logic [DW-1:0] a5, d[5];
  always #5 clk = ~clk;
  ddr3_rdback_adapter dut (
    .clk(clk), .rst(rst), .init_calib_complete(cal), .rd_issue(rd_issue),
    .rd_issue_maint(rd_issue_maint), .phy_rddata_valid(phy_rddata_valid), .phy_rd_data(phy_rd_data),
    .rdback_data(rdback_data), .rdback_valid(rdback_valid), .rdback_ready(rdback_ready),
    .outstanding(outstanding), .idle(idle), .err_unexpected(err_unexpected),
    .err_overflow(err_overflow), .err_tag_full(err_tag_full), .err_timeout(err_timeout)
  );
  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_model();
    chk("valid", rdback_valid, oq.size() != 0);
    if (oq.size() != 0) chk("data", rdback_data, oq[0]);
    chk("outstanding", outstanding, tq.size());
    chk("idle", idle, tq.size() == 0 && oq.size() == 0);
    chk("err_unexpected", err_unexpected, m_unexp);
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_tag_full", err_tag_full, m_full);
    chk("err_timeout", err_timeout, m_tmo);
  endtask
  // one clock: drive inputs, advance the model by the same cycle, then compare
  task automatic cycle(input bit iss, input bit maint, input bit vld, input logic [DW-1:0] data,
                       input bit rdy, input bit c = 1);
    bit rd, i, r;
    rd_issue = iss; rd_issue_maint = maint; phy_rddata_valid = vld;
    phy_rd_data = data; rdback_ready = rdy; cal = c;
    @(posedge clk);
    rd = oq.size() != 0 && rdy;
    i = iss && c;
    r = vld && c;
    if (!r && tq.size() != 0 && quiet == 255) m_tmo = 1;
    quiet = (r || tq.size() == 0) ? 0 : (quiet < 255 ? quiet + 1 : quiet);
    if (rd) void'(oq.pop_front());
    if (r) begin
      if (tq.size() == 0) m_unexp = 1;
      else if (!tq.pop_front()) begin
        if (oq.size() < OD) oq.push_back(data);
        else m_ovf = 1;
      end
    end
    if (i) begin
      if (tq.size() < TD) tq.push_back(maint);
      else m_full = 1;
    end
    #1;
    check_model();
  endtask
  task automatic idle_cycles(input int n, input bit rdy = 0);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, '0, rdy);
  endtask
  task automatic do_reset();
    rst = 1; rd_issue = 0; phy_rddata_valid = 0; rdback_ready = 0; cal = 1;
    @(posedge clk);
    #1;
    rst = 0;
    tq.delete(); oq.delete();
    m_unexp = 0; m_ovf = 0; m_full = 0; m_tmo = 0; quiet = 0;
  endtask
  initial begin
    a5 = {64{8'hA5}};
    for (int i = 0; i < 5; i++) d[i] = rnd();
    do_reset();
    chk("rst_data", rdback_data, '0);
    check_model();
    // single user read
    cycle(1, 0, 0, '0, 1);
    chk("t1_out1", outstanding, 1);
    idle_cycles(2, 1);
    cycle(0, 0, 1, a5, 1);
    chk("t1_valid", rdback_valid, 1);
    chk("t1_data", rdback_data, a5);
    chk("t1_out0", outstanding, 0);
    idle_cycles(1, 1);
    chk("t1_valid_off", rdback_valid, 0);
    chk("t1_idle", idle, 1);
    // maintenance interleave
    cycle(1, 0, 0, '0, 0); cycle(1, 1, 0, '0, 0); cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, d[i], 0);
    chk("t2_head0", rdback_data, d[0]);
    cycle(0, 0, 0, '0, 1);
    chk("t2_head2", rdback_data, d[2]);
    cycle(0, 0, 0, '0, 1);
    chk("t2_empty", rdback_valid, 0);
    chk("t2_errs", {err_unexpected, err_overflow, err_tag_full, err_timeout}, 0);
    // backpressure overflow
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, d[i], 0);
    chk("t3_ovf", err_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_drain%0d", i), rdback_data, d[i]);
      cycle(0, 0, 0, '0, 1);
    end
    chk("t3_drained", rdback_valid, 0);
    // unexpected return and tag full
    do_reset();
    cycle(0, 0, 1, rnd(), 1);
    chk("t4_unexp", err_unexpected, 1);
    chk("t4_noout", rdback_valid, 0);
    do_reset();
    for (int i = 0; i < 17; i++) cycle(1, 0, 0, '0, 0);
    chk("t4_out16", outstanding, 16);
    chk("t4_full", err_tag_full, 1);
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, 1, 0, '0, 1);
    for (int i = 0; i < 17; i++) cycle(1, 1, 1, rnd(), 1);
    chk("t4_out_hold", outstanding, 16);
    chk("t4_full_ok", err_tag_full, 0);
    chk("t4_unexp_ok", err_unexpected, 0);
    // timeout
    do_reset();
    cycle(1, 0, 0, '0, 0);
    idle_cycles(255);
    chk("t5_tmo_before", err_timeout, 0);
    idle_cycles(1);
    chk("t5_tmo", err_timeout, 1);
    do_reset();
    cycle(1, 0, 0, '0, 0);
    idle_cycles(199);
    cycle(0, 0, 1, a5, 0);
    idle_cycles(100);
    chk("t5_no_tmo", err_timeout, 0);
    // reset mid-flight
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0, 0);
    cycle(0, 0, 1, d[0], 0);
    chk("t6_buffered", rdback_valid, 1);
    do_reset();
    chk("t6_out", outstanding, 0);
    chk("t6_valid", rdback_valid, 0);
    chk("t6_idle", idle, 1);
    cycle(0, 0, 1, d[1], 1);
    chk("t6_unexp", err_unexpected, 1);
    // random traffic
    do_reset();
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 9) < 4, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 4,
            rnd(), $urandom_range(0, 9) < 6, $urandom_range(0, 9) != 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
